// File: rtl/mult_arbiter_pkg.sv
// Shared constants for the two-requester multiplier arbiter.
// Operand width default, pipeline depth, ID width and arbiter reset state.
package mult_arbiter_pkg;

    localparam int N_DEFAULT = 32;
    localparam int LAT       = 2;
    localparam int ID_W      = 1;

    // Requester 0 must win the first contended grant after reset.
    localparam logic [ID_W-1:0] LAST_GRANT_RST = 1'b1;

endpackage

// File: rtl/mult_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter with its own last-grant register.
// Ports: clk, reset, req[1:0], advance -> grant[1:0] (one-hot), grant_id.
module rr_arbiter2
    import mult_arbiter_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      req,
    input  logic            advance,
    output logic [1:0]      grant,
    output logic [ID_W-1:0] grant_id
);

    logic [ID_W-1:0] last_grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= LAST_GRANT_RST;
        end else if (advance) begin
            last_grant <= grant_id;
        end
    end

    always_comb begin
        grant_id = '0;
        if (req == 2'b11) begin
            grant_id = ~last_grant;
        end else if (req[1]) begin
            grant_id = 1'b1;
        end
        grant = '0;
        if (|req) begin
            grant[grant_id] = 1'b1;
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one 2-stage pipelined signed multiplier between two requesters.
// Ports: req_* (valid/ready/operands), mul_* (to multiplier), res_* (result), busy.
module mult_arbiter
    import mult_arbiter_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [2*N-1:0]   req_a,
    input  logic [2*N-1:0]   req_b,
    output logic             mul_en,
    output logic [N-1:0]     mul_a,
    output logic [N-1:0]     mul_b,
    input  logic [2*N-1:0]   mul_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ID_W-1:0]  res_id,
    output logic [2*N-1:0]   res_data,
    output logic             busy
);

    logic [1:0]      grant;
    logic [ID_W-1:0] grant_id;
    logic            issue;

    // Shadow of the multiplier pipeline: validity and owner per stage.
    logic            v1;
    logic            v2;
    logic [ID_W-1:0] id1;
    logic [ID_W-1:0] id2;

    rr_arbiter2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .req      (req_valid),
        .advance  (issue),
        .grant    (grant),
        .grant_id (grant_id)
    );

    // Only a valid result refused by the consumer freezes the pipe;
    // a bubble at the output always lets the pipe advance.
    assign mul_en    = !(v2 && !res_ready);
    assign req_ready = grant & {2{mul_en}};
    assign issue     = |(req_valid & req_ready);

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (|req_valid) begin
            mul_a = grant_id ? req_a[2*N-1:N] : req_a[N-1:0];
            mul_b = grant_id ? req_b[2*N-1:N] : req_b[N-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1  <= 1'b0;
            v2  <= 1'b0;
            id1 <= '0;
            id2 <= '0;
        end else if (mul_en) begin
            v1  <= issue;
            id1 <= grant_id;
            v2  <= v1;
            id2 <= id1;
        end
    end

    assign res_valid = v2;
    assign res_id    = id2;
    assign res_data  = mul_result;
    assign busy      = v1 | v2;

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Shares one pipelined signed N x N multiplier (2-stage: registered operands, registered 2N-bit product, common enable) between two requesters.
- Round-robin arbitration, valid/ready handshake on the request side, and valid/ready with requester ID on the result side.
- Drives the multiplier's enable to stall the whole pipeline under result backpressure, and tracks the requester ID of every in-flight operation.

Parameters:
- N, 32, operand width; product width is 2N.
- LAT, 2, multiplier latency in enabled cycles; fixed at 2 (only value supported).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester accept; a transfer occurs when req_valid[i] & req_ready[i].
- req_a  in  2N  operand A; requester i uses bits [i*N +: N], signed.
- req_b  in  2N  operand B, same packing as req_a.
- mul_en  out  1  enable to all multiplier registers.
- mul_a  out  N  operand A to the multiplier input register.
- mul_b  out  N  operand B to the multiplier input register.
- mul_result  in  2N  registered signed product from the multiplier.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumer ready.
- res_id  out  1  requester ID owning the current result.
- res_data  out  2N  equals mul_result (combinational passthrough).
- busy  out  1  high while any operation is in flight (v1 | v2).

Behaviour:
- Shadow pipeline, updated only when mul_en=1: stage 1 holds (v1, id1); stage 2 holds (v2, id2). On enable: v1 <= issue, id1 <= grant_id; v2 <= v1, id2 <= id1.
- Stall: mul_en = !(v2 & !res_ready). A bubble at stage 2 never stalls, whatever res_ready is.
- Outputs: res_valid = v2, res_id = id2.
- Arbitration (combinational):
  - One requesting: it wins.
  - Both requesting: the requester that is not last_grant wins.
  - grant_id selects the operands: mul_a/mul_b = winner's slice; zeros when nobody requests.
- Handshake:
  - req_ready[i] = (winner == i) & mul_en; at most one bit is high.
  - issue = |(req_valid & req_ready).
  - last_grant updates to grant_id only on issue.
  - req_ready may depend combinationally on req_valid and res_ready. req_valid must not depend on req_ready.
- Latency: a request accepted in cycle T gives res_valid in cycle T+2 when no stall occurs. Each stall cycle adds one.
- Throughput: one operation per cycle when res_ready=1. Back-to-back requests from both requesters alternate A,B,A,B.
- Stall hold: while stalled, v1/id1/v2/id2/last_grant hold, req_ready=0, and res_valid/res_id/res_data stay stable. The multiplier registers hold because mul_en=0.
- Reset: asynchronous. Clears v1, v2, id1, id2 and last_grant (=1, so requester 0 wins first).
- Reset values: res_valid=0, res_id=0, busy=0, mul_en=1. req_ready follows req_valid (requester 0 has priority).
- Reset mid-operation: in-flight operations are dropped with no result. The multiplier's synchronous reset is driven separately by the system, not by this block.
- Arithmetic: operands pass through unmodified. Signedness is the multiplier's job; the result is the full 2N-bit product.

Decomposition:
- Shared package: N default, LAT, requester-ID width (1), reset value of last_grant.
- Natural sub-module: rr_arbiter2 (req[1:0], last_grant, advance -> grant[1:0], grant_id, last_grant register).
- mult_arbiter holds the shadow pipeline, stall logic and operand mux.
- The integration bench instantiates mult_arbiter plus the multiplier.

Test Plan:
- Single op: requester 0 sends A=3, B=-5 in cycle 0 with res_ready=1 -> cycle 2: res_valid=1, res_id=0, res_data=-15 (64-bit sign-extended); busy falls in cycle 3.
- Contention: both requesters hold valid for 4 cycles (r0: 2x2, r1: 7x7) with res_ready=1 -> accepts alternate r0,r1,r0,r1; results 4,49,4,49 with ids 0,1,0,1 in cycles 2-5.
- Backpressure: pipeline full (2 ops in flight), res_ready=0 for 3 cycles -> mul_en=0, req_ready=00, result held stable. On release, results drain in order with no loss or duplication.
- Bubble at output: res_ready=0 with v2=0 and v1=1 -> mul_en=1; the op advances to stage 2, then stalls.
- Extremes: A=0x80000000, B=0x80000000 -> res_data=0x4000000000000000. A=-1, B=1 -> 0xFFFFFFFFFFFFFFFF.
- Async reset asserted mid-cycle with 2 ops in flight -> res_valid and busy drop immediately, no result appears afterward, and the first grant after reset goes to requester 0.
